// File: rtl/io_port_bank_if.sv
// Bus bundle between io_port_bank and its core/host drivers.
// IO_TIMESTAMP_EN adds the out_stamp signal.
interface io_port_bank_if #(
   parameter int unsigned CW = 16
) ();
   logic [2:0]    io_n;
   logic          io_wr;
   logic          io_rd;
   logic [7:0]    io_wdata;
   logic [7:0]    io_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_port;
   logic [7:0]    out_data;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_port;
   logic [7:0]    in_data;
   logic [3:0]    ef;
   logic [CW-1:0] count;
   logic [2:0]    err;
`ifdef IO_TIMESTAMP_EN
   logic [CW-1:0] out_stamp;
`endif

   // Core/host side.
   modport master (
      output io_n, io_wr, io_rd, io_wdata, out_ready, in_valid, in_port, in_data,
`ifdef IO_TIMESTAMP_EN
      input  out_stamp,
`endif
      input  io_rdata, out_valid, out_port, out_data, in_ready, ef, count, err
   );

   // Port bank side.
   modport slave (
      input  io_n, io_wr, io_rd, io_wdata, out_ready, in_valid, in_port, in_data,
`ifdef IO_TIMESTAMP_EN
      output out_stamp,
`endif
      output io_rdata, out_valid, out_port, out_data, in_ready, ef, count, err
   );
endinterface

// File: rtl/io_port_bank.sv
// I/O port bank: OUT bytes go to a tagged output FIFO, INP bytes come from host-filled mailboxes.
// Defining IO_TIMESTAMP_EN stores the cycle count with each FIFO entry (out_stamp).
module io_port_bank #(
   parameter int unsigned NPORTS = 7,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CW     = 16
) (
   input logic           clk_i,
   input logic           rst_i,
   io_port_bank_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   function automatic logic port_ok(input logic [2:0] n);
      return (n != 3'd0) && (32'(n) <= NPORTS);
   endfunction

   ptr_t              wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0]        fport_q [DEPTH];
   logic [7:0]        fdata_q [DEPTH];
`ifdef IO_TIMESTAMP_EN
   logic [CW-1:0]     fstamp_q [DEPTH];
`endif
   logic [NPORTS-1:0] mb_full_q, mb_full_d, fill;
   logic [7:0]        mb_data_q [NPORTS];
   logic [7:0]        rdata_q, rdata_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2:0]        err_q, err_d;
   logic              empty, full, pop, push, io_ok, in_ready, rd_hit;

   always_comb begin : fifo_ctl
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      io_ok  = port_ok(bus.io_n);
      pop    = !empty && bus.out_ready;
      // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
      push   = bus.io_wr && io_ok && (!full || pop);
      wptr_d = push ? wptr_q + ptr_t'(1) : wptr_q;
      rptr_d = pop ? rptr_q + ptr_t'(1) : rptr_q;
   end

   always_comb begin : mailbox_ctl
      in_ready  = 1'b0;
      fill      = '0;
      rd_hit    = 1'b0;
      mb_full_d = mb_full_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      count_d   = count_q + CW'(1);
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (bus.in_port == 3'(k + 1)) begin
            in_ready = !mb_full_q[k];
            fill[k]  = bus.in_valid && !mb_full_q[k];
         end
      end
      if (bus.io_rd) begin
         rdata_d = 8'hFF;
         for (int unsigned k = 0; k < NPORTS; k++) begin
            if ((bus.io_n == 3'(k + 1)) && mb_full_q[k]) begin
               rdata_d      = mb_data_q[k];
               mb_full_d[k] = 1'b0;
               rd_hit       = 1'b1;
            end
         end
         if (!io_ok) begin
            err_d[2] = 1'b1;
         end else if (!rd_hit) begin
            err_d[1] = 1'b1;
         end
      end
      // Fill only happens into an empty mailbox, so it never collides with a read-clear.
      mb_full_d = mb_full_d | fill;
      if (bus.io_wr && !io_ok) err_d[2] = 1'b1;
      if (bus.io_wr && io_ok && !push) err_d[0] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         mb_full_q <= '0;
         rdata_q   <= 8'h00;
         count_q   <= '0;
         err_q     <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         mb_full_q <= mb_full_d;
         rdata_q   <= rdata_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fport_q[i]  <= '0;
            fdata_q[i]  <= '0;
`ifdef IO_TIMESTAMP_EN
            fstamp_q[i] <= '0;
`endif
         end
         for (int unsigned k = 0; k < NPORTS; k++) mb_data_q[k] <= '0;
      end else begin
         if (push) begin
            fport_q[wptr_q[AW-1:0]]  <= bus.io_n;
            fdata_q[wptr_q[AW-1:0]]  <= bus.io_wdata;
`ifdef IO_TIMESTAMP_EN
            fstamp_q[wptr_q[AW-1:0]] <= count_q;
`endif
         end
         for (int unsigned k = 0; k < NPORTS; k++) begin
            if (fill[k]) mb_data_q[k] <= bus.in_data;
         end
      end
   end

   assign bus.out_valid = !empty;
   assign bus.out_port  = fport_q[rptr_q[AW-1:0]];
   assign bus.out_data  = fdata_q[rptr_q[AW-1:0]];
`ifdef IO_TIMESTAMP_EN
   assign bus.out_stamp = fstamp_q[rptr_q[AW-1:0]];
`endif
   assign bus.in_ready  = in_ready;
   assign bus.io_rdata  = rdata_q;
   assign bus.count     = count_q;
   assign bus.err       = err_q;

   for (genvar g = 0; g < 4; g++) begin : g_ef
      if (g < NPORTS) begin : g_on
         assign bus.ef[g] = mb_full_q[g];
      end else begin : g_off
         assign bus.ef[g] = 1'b0;
      end
   end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised I/O port subsystem between the cdp1802 core and the simulation host; replaces the fixed, ad-hoc bus_in/bus_out/n wiring and free-running count of the current harness.
- OUT instructions push tagged bytes into an output FIFO that the host drains.
- INP instructions read per-port mailboxes that the host fills.
- Mailbox status drives EF flags; cycle counter and sticky error flags provided for the bench.

Parameters:
NPORTS, 7, number of active ports (1..7); ports numbered 1..NPORTS, port 0 never valid
DEPTH, 4, output FIFO entries (power of two, >=2)
CW, 16, cycle counter width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
io_n  input  3  port number from core (N field of OUT/INP)
io_wr  input  1  OUT strobe, one cycle per transfer; data on io_wdata
io_rd  input  1  INP strobe, one cycle per transfer
io_wdata  input  8  byte written by core
io_rdata  output  8  byte returned to core, registered
out_valid  output  1  output FIFO non-empty
out_ready  input  1  host accepts head entry
out_port  output  3  port tag of head entry
out_data  output  8  data byte of head entry
in_valid  input  1  host offers a mailbox byte
in_ready  output  1  addressed mailbox empty
in_port  input  3  target mailbox
in_data  input  8  mailbox byte
ef  output  4  ef[k] = mailbox k+1 full (k=0..3); bit 0 if port k+1 > NPORTS
count  output  CW  free-running cycle counter
err  output  3  sticky: [0] FIFO overflow, [1] mailbox underflow, [2] bad port

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO empty; all mailboxes empty.
  - io_rdata=8'h00, count=0, err=0.
  - Outputs: out_valid=0, in_ready=1 for valid in_port, ef=0.
- count: +1 every cycle, wraps 2^CW-1 -> 0; no saturation.
- Port validity: io_n in 1..NPORTS. Any io_wr/io_rd with invalid io_n:
  - sets err[2];
  - writes are dropped;
  - reads return 8'hFF.
- OUT path:
  - io_wr with valid port pushes {io_n, io_wdata}.
  - Push accepted if FIFO not full, or full with out_valid&out_ready in the same cycle (simultaneous pop frees the slot).
  - Otherwise the byte is dropped and err[0] set; FIFO contents unchanged.
- FIFO:
  - Circular, log2(DEPTH)+1-bit read/write pointers; full when pointers differ only in MSB.
  - out_port/out_data are the head entry, valid whenever out_valid=1.
  - Pop on out_valid&out_ready.
  - Push to an empty FIFO is visible as out_valid=1 the cycle after io_wr; no bypass.
- INP path:
  - io_rd with valid port: io_rdata updates on the next edge (1-cycle latency, same as the ram q).
  - If the mailbox is full: returns its byte and clears full.
  - If empty: returns 8'hFF and sets err[1].
  - io_rdata holds its value until the next io_rd.
- Host fill:
  - in_ready = mailbox[in_port] empty (combinational on in_port); in_ready=0 for invalid in_port.
  - in_valid&in_ready loads the byte and sets full; visible on ef/io_rd from the next cycle.
  - in_valid with an invalid in_port is ignored; err is not set.
- Simultaneous io_rd and host fill on the same port:
  - in_ready reflects pre-edge state, so a fill only occurs if the mailbox was empty.
  - io_rd then sees empty (underflow, 8'hFF) and the fill is not lost.
- io_wr and io_rd in the same cycle: both are processed independently.
- err bits clear only on reset.
- Reset mid-transfer: pending FIFO entries and mailbox contents are discarded; no partial state survives.

Optional Feature:
- IO_TIMESTAMP_EN defined:
  - Each FIFO entry also stores count sampled on the push cycle.
  - Extra output out_stamp [CW-1:0] presents the head entry's timestamp alongside out_data; reset value 0.
- Undefined:
  - No timestamp storage; out_stamp port absent.
  - All other behaviour identical.

Test Plan:
- Reset, then 3 cycles idle -> count=3, out_valid=0, ef=0, err=0, io_rdata=00.
- io_wr port 2 data 8'hA5, out_ready=0 -> next cycle out_valid=1, out_port=2, out_data=A5; out_ready=1 one cycle -> out_valid=0.
- DEPTH=4, five io_wr (ports 1, data 01..05), out_ready=0:
  - FIFO holds 01..04; err[0]=1.
  - Repeat with out_ready=1 on the 5th write -> 05 accepted, err[0]=0.
- Host fills port 3 with 8'h3C:
  - ef[2]=1; io_rd port 3 -> io_rdata=3C next cycle, ef[2]=0.
  - Second io_rd port 3 -> io_rdata=FF, err[1]=1.
- io_wr port 0 and io_rd port 7 with NPORTS=6 -> err[2]=1, FIFO empty, io_rdata=FF.
- CW=4, run 17 cycles after reset -> count=1 (wrap); with IO_TIMESTAMP_EN, a push on cycle 5 -> out_stamp=5.
